// File: rtl/fwd_ctrl.sv
// EX-stage operand-forwarding producer: tracks EX/LS/WB destinations, drives registered
// rs1/rs2 source selects and load-use / divide hazard controls. WB bypass: FWD_WB_BYPASS_EN.
module fwd_ctrl #(
    parameter int REG_AW  = 5,
    parameter int DIV_LAT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_rd_wen_i,
    input  logic              id_is_load_i,
    input  logic              id_div_en_i,
    input  logic              flush_i,
    output logic [1:0]        rs1_sel_o,
    output logic [1:0]        rs2_sel_o,
    output logic              stall_id_o,
    output logic              bubble_ex_o,
    output logic              stall_pipe_o
);

    localparam int CW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);
`ifdef FWD_WB_BYPASS_EN
    localparam bit WB_BYPASS = 1'b1;
`else
    localparam bit WB_BYPASS = 1'b0;  // regfile is write-first, WB result already visible
`endif

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wen;
        logic              is_load;
    } slot_t;

    slot_t             ex_q, ex_d, ls_q, ls_d, wb_q, wb_d;
    logic [1:0]        rs1_sel_q, rs1_sel_d, rs2_sel_q, rs2_sel_d;
    logic [CW-1:0]     div_cnt_q, div_cnt_d;
    logic              load_use, stall_pipe, stall_id, id_adv;

    function automatic logic match(input slot_t s, input logic [REG_AW-1:0] rs, input logic used);
        return s.valid & s.wen & (s.rd == rs) & (rs != '0) & used;
    endfunction

    function automatic logic [1:0] pick(input slot_t ex, input slot_t ls, input slot_t wb,
                                        input logic [REG_AW-1:0] rs, input logic used);
        if (match(ex, rs, used))                    return 2'd1;
        else if (match(ls, rs, used))               return 2'd2;
        else if (WB_BYPASS && match(wb, rs, used))  return 2'd3;
        else                                        return 2'd0;
    endfunction

    always_comb begin
        stall_pipe = (div_cnt_q != '0);
        load_use   = id_valid_i & ex_q.is_load &
                     (match(ex_q, id_rs1_i, id_rs1_used_i) | match(ex_q, id_rs2_i, id_rs2_used_i));
        stall_id   = (load_use & ~flush_i) | stall_pipe;
        id_adv     = id_valid_i & ~stall_id & ~flush_i;

        ex_d      = ex_q;
        ls_d      = ls_q;
        wb_d      = wb_q;
        rs1_sel_d = rs1_sel_q;
        rs2_sel_d = rs2_sel_q;
        div_cnt_d = div_cnt_q;

        if (stall_pipe) begin
            div_cnt_d = div_cnt_q - CW'(1);
        end else begin
            wb_d = ls_q;
            ls_d = ex_q;
            ex_d = id_adv ? slot_t'{1'b1, id_rd_i, id_rd_wen_i, id_is_load_i} : '0;
            rs1_sel_d = id_adv ? pick(ex_q, ls_q, wb_q, id_rs1_i, id_rs1_used_i) : 2'd0;
            rs2_sel_d = id_adv ? pick(ex_q, ls_q, wb_q, id_rs2_i, id_rs2_used_i) : 2'd0;
            if (id_adv & id_div_en_i) div_cnt_d = DIV_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            ls_q      <= '0;
            wb_q      <= '0;
            rs1_sel_q <= 2'd0;
            rs2_sel_q <= 2'd0;
            div_cnt_q <= '0;
        end else begin
            ex_q      <= ex_d;
            ls_q      <= ls_d;
            wb_q      <= wb_d;
            rs1_sel_q <= rs1_sel_d;
            rs2_sel_q <= rs2_sel_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    assign rs1_sel_o    = rs1_sel_q;
    assign rs2_sel_o    = rs2_sel_q;
    assign stall_id_o   = stall_id;
    assign bubble_ex_o  = load_use & ~flush_i & ~stall_pipe;
    assign stall_pipe_o = stall_pipe;

endmodule
